// File: rtl/ir_tx_pkg.sv
// Shared types and elaboration-time helpers for the consumer-IR transmit path.
package ir_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        GAP_MARK,
        GAP_SPACE,
        TRAIL_MARK
    } state_t;

    function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
        return (clk_hz / 1_000_000) * us;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed for a counter running 0..n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Free-running carrier divider; carrier_hi is high for the upper half of each period.
module ir_carrier_gen
    import ir_tx_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 125_000_000,
    parameter int unsigned CARRIER_HZ = 38_000
) (
    input  logic clk,
    input  logic rst,
    output logic carrier_hi
);

    localparam int unsigned CP   = CLK_HZ / CARRIER_HZ;
    localparam int unsigned HALF = CP / 2;
    localparam int unsigned CW   = cnt_width(CP);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = (cnt == CW'(CP - 1)) ? '0 : cnt + CW'(1);
    end

    // carrier_hi is registered from the next count so it always matches cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            carrier_hi <= (HALF == 0);
        end else begin
            cnt        <= cnt_nxt;
            carrier_hi <= (cnt_nxt >= CW'(HALF));
        end
    end

endmodule

// File: rtl/ir_frame_tx.sv
// Two-segment pulse-distance IR frame transmitter with carrier modulation.
module ir_frame_tx
    import ir_tx_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 125_000_000,
    parameter int unsigned CARRIER_HZ    = 38_000,
    parameter int unsigned SEG0_BITS     = 35,
    parameter int unsigned SEG1_BITS     = 32,
    parameter int unsigned LEAD_MARK_US  = 9000,
    parameter int unsigned LEAD_SPACE_US = 4500,
    parameter int unsigned BIT_MARK_US   = 600,
    parameter int unsigned ZERO_SPACE_US = 600,
    parameter int unsigned ONE_SPACE_US  = 1600,
    parameter int unsigned GAP_SPACE_US  = 20000,
    parameter bit          OUT_INVERT    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic [SEG0_BITS-1:0] seg0_data,
    input  logic [SEG1_BITS-1:0] seg1_data,
    output logic                 busy,
    output logic                 done,
    output logic                 ir_out
);

    localparam int unsigned T_LM   = us_to_cycles(CLK_HZ, LEAD_MARK_US);
    localparam int unsigned T_LS   = us_to_cycles(CLK_HZ, LEAD_SPACE_US);
    localparam int unsigned T_BM   = us_to_cycles(CLK_HZ, BIT_MARK_US);
    localparam int unsigned T_ZERO = us_to_cycles(CLK_HZ, ZERO_SPACE_US);
    localparam int unsigned T_ONE  = us_to_cycles(CLK_HZ, ONE_SPACE_US);
    localparam int unsigned T_GAP  = us_to_cycles(CLK_HZ, GAP_SPACE_US);
    localparam int unsigned T_MAX  = max_u(max_u(max_u(T_LM, T_LS), max_u(T_BM, T_ZERO)),
                                           max_u(T_ONE, T_GAP));
    localparam int unsigned TW     = cnt_width(T_MAX);
    localparam int unsigned IW     = cnt_width(max_u(SEG0_BITS, SEG1_BITS));

    state_t               state, state_nxt;
    logic [TW-1:0]        timer, timer_nxt;
    logic [IW-1:0]        bit_idx, bit_idx_nxt;
    logic                 seg_sel, seg_sel_nxt;
    logic [SEG0_BITS-1:0] seg0_q, seg0_nxt;
    logic [SEG1_BITS-1:0] seg1_q, seg1_nxt;
    logic                 done_nxt;
    logic                 carrier_hi;
    logic                 envelope_c;
    logic                 cur_bit_c;
    logic                 phase_end_c;
    int unsigned          phase_len_c;

    ir_carrier_gen #(
        .CLK_HZ     (CLK_HZ),
        .CARRIER_HZ (CARRIER_HZ)
    ) u_carrier (
        .clk        (clk),
        .rst        (rst),
        .carrier_hi (carrier_hi)
    );

    // Current bit, phase length and envelope for the present state.
    always_comb begin
        cur_bit_c = 1'b0;
        for (int k = 0; k < int'(SEG0_BITS); k++) begin
            if (!seg_sel && bit_idx == IW'(k)) cur_bit_c = seg0_q[k];
        end
        for (int k = 0; k < int'(SEG1_BITS); k++) begin
            if (seg_sel && bit_idx == IW'(k)) cur_bit_c = seg1_q[k];
        end

        envelope_c = (state inside {LEAD_MARK, BIT_MARK, GAP_MARK, TRAIL_MARK});

        case (state)
            LEAD_MARK:                       phase_len_c = T_LM;
            LEAD_SPACE:                      phase_len_c = T_LS;
            BIT_MARK, GAP_MARK, TRAIL_MARK:  phase_len_c = T_BM;
            BIT_SPACE:                       phase_len_c = cur_bit_c ? T_ONE : T_ZERO;
            GAP_SPACE:                       phase_len_c = T_GAP;
            default:                         phase_len_c = 1;
        endcase

        phase_end_c = (timer == TW'(phase_len_c - 1));
    end

    // Next-state logic.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer + TW'(1);
        bit_idx_nxt = bit_idx;
        seg_sel_nxt = seg_sel;
        seg0_nxt    = seg0_q;
        seg1_nxt    = seg1_q;
        done_nxt    = 1'b0;

        if (state == IDLE) begin
            timer_nxt = '0;
            if (frame_valid && frame_ready) begin
                seg0_nxt    = seg0_data;
                seg1_nxt    = seg1_data;
                seg_sel_nxt = 1'b0;
                bit_idx_nxt = IW'(SEG0_BITS - 1);
                state_nxt   = LEAD_MARK;
            end
        end else if (phase_end_c) begin
            timer_nxt = '0;
            case (state)
                LEAD_MARK:  state_nxt = LEAD_SPACE;
                LEAD_SPACE: state_nxt = BIT_MARK;
                BIT_MARK:   state_nxt = BIT_SPACE;
                BIT_SPACE: begin
                    if (bit_idx == '0) begin
                        state_nxt = seg_sel ? TRAIL_MARK : GAP_MARK;
                    end else begin
                        bit_idx_nxt = bit_idx - IW'(1);
                        state_nxt   = BIT_MARK;
                    end
                end
                GAP_MARK:   state_nxt = GAP_SPACE;
                GAP_SPACE: begin
                    seg_sel_nxt = 1'b1;
                    bit_idx_nxt = IW'(SEG1_BITS - 1);
                    state_nxt   = BIT_MARK;
                end
                TRAIL_MARK: begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            seg_sel     <= 1'b0;
            seg0_q      <= '0;
            seg1_q      <= '0;
            frame_ready <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            ir_out      <= OUT_INVERT;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            bit_idx     <= bit_idx_nxt;
            seg_sel     <= seg_sel_nxt;
            seg0_q      <= seg0_nxt;
            seg1_q      <= seg1_nxt;
            frame_ready <= (state_nxt == IDLE);
            busy        <= (state_nxt != IDLE);
            done        <= done_nxt;
            ir_out      <= (envelope_c & carrier_hi) ^ OUT_INVERT;
        end
    end

endmodule
